// File: rtl/ggx_halfvec_join.sv
// Pairs the phi and theta sample streams through independent FIFOs and forms the
// tangent-space GGX half vector H = (sinT*cosP, sinT*sinP, cosT) on a valid/ready output.

module ggx_halfvec_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   occ,
   output logic                     ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;

   assign empty = (occ == '0);
   assign full  = (occ == FULL_CNT);
   // A pop on the same cycle frees the head slot, so a full FIFO can still accept.
   assign wr_en = push && (!full || pop);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)      occ <= occ + (AW+1)'(1);
         else if (pop && !wr_en) occ <= occ - (AW+1)'(1);
         if (push && full && !pop) ovf <= 1'b1;
      end
   end
endmodule

module ggx_halfvec_join #(
   parameter int FRAC_BITS = 32,
   parameter int DEPTH     = 8,
   parameter int SLACK     = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 phi_valid,
   input  logic [FRAC_BITS-1:0] cos_phi,
   input  logic [FRAC_BITS-1:0] sin_phi,
   input  logic                 th_valid,
   input  logic [FRAC_BITS-1:0] cos_theta,
   input  logic [FRAC_BITS-1:0] sin_theta,
   output logic                 issue_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FRAC_BITS-1:0] hx,
   output logic [FRAC_BITS-1:0] hy,
   output logic [FRAC_BITS-1:0] hz,
   output logic                 ovf_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = 2 * FRAC_BITS;
   localparam int FB = FRAC_BITS - 2;
   localparam logic [AW:0] ISSUE_LIM = (AW+1)'(DEPTH - SLACK - 1);
   localparam logic signed [PW-1:0] HALF_LSB = PW'(1) <<< (FB - 1);

   // Q4.60 product back to Q2.30, round half toward +inf; range keeps |p| <= 1.0.
   function automatic logic signed [FRAC_BITS-1:0] round_q(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] t;
      t = (p + HALF_LSB) >>> FB;
      return t[FRAC_BITS-1:0];
   endfunction

   logic [PW-1:0] phi_head;
   logic [PW-1:0] th_head;
   logic          phi_empty, th_empty, phi_full, th_full;
   logic [AW:0]   phi_occ, th_occ;
   logic          phi_ovf, th_ovf;
   logic          en, pop;

   logic signed [FRAC_BITS-1:0] cp_h, sp_h, ct_h, st_h;
   logic signed [PW-1:0]        prod_x_p1, prod_y_p1;
   logic signed [FRAC_BITS-1:0] ct_p1;
   logic                        vld_p1;

   assign en  = !(out_valid && !out_ready);
   assign pop = en && !phi_empty && !th_empty;

   ggx_halfvec_fifo #(.W(PW), .DEPTH(DEPTH)) u_phi_fifo (
      .clk(clk), .rst_n(rst_n), .push(phi_valid), .din({cos_phi, sin_phi}), .pop(pop),
      .dout(phi_head), .empty(phi_empty), .full(phi_full), .occ(phi_occ), .ovf(phi_ovf)
   );

   ggx_halfvec_fifo #(.W(PW), .DEPTH(DEPTH)) u_th_fifo (
      .clk(clk), .rst_n(rst_n), .push(th_valid), .din({cos_theta, sin_theta}), .pop(pop),
      .dout(th_head), .empty(th_empty), .full(th_full), .occ(th_occ), .ovf(th_ovf)
   );

   assign cp_h    = phi_head[PW-1:FRAC_BITS];
   assign sp_h    = phi_head[FRAC_BITS-1:0];
   assign ct_h    = th_head[PW-1:FRAC_BITS];
   assign st_h    = th_head[FRAC_BITS-1:0];
   assign ovf_err = phi_ovf | th_ovf;

   // S1: full-precision products of the popped pair
   always_ff @(posedge clk) begin
      if (en) begin
         prod_x_p1 <= PW'(st_h) * PW'(cp_h);
         prod_y_p1 <= PW'(st_h) * PW'(sp_h);
         ct_p1     <= ct_h;
      end
   end

   // S2: rounded output register, held while downstream stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         out_valid   <= 1'b0;
         hx          <= '0;
         hy          <= '0;
         hz          <= '0;
         issue_ready <= 1'b1;
      end else begin
         if (en) begin
            vld_p1    <= pop;
            out_valid <= vld_p1;
            if (vld_p1) begin
               hx <= round_q(prod_x_p1);
               hy <= round_q(prod_y_p1);
               hz <= ct_p1;
            end
         end
         issue_ready <= (phi_occ <= ISSUE_LIM) && (th_occ <= ISSUE_LIM);
      end
   end
endmodule

// File: tb/tb_ggx_halfvec_join.sv
// Directed bench for ggx_halfvec_join: hand-computed half vectors, latency, stall,
// FIFO fill/overflow and mid-stream reset.

module tb_ggx_halfvec_join;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        phi_valid, th_valid, out_ready;
   logic [31:0] cos_phi, sin_phi, cos_theta, sin_theta;
   logic        issue_ready, out_valid, ovf_err;
   logic [31:0] hx, hy, hz;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [95:0] got_q [$];
   int          cyc_q [$];

   // Stream table: with sinT = 1.0 the half vector is exactly (cosP, sinP, cosT).
   logic [31:0] vcp [5] = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000, 32'h0500_0000};
   logic [31:0] vsp [5] = '{32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFD0, 32'hFFFF_FFC0, 32'hFFFF_FFB0};
   logic [31:0] vct [5] = '{32'h0800_0000, 32'h1000_0000, 32'h1800_0000, 32'h2000_0000, 32'h2800_0000};
   localparam logic [31:0] ONE = 32'h4000_0000;

   ggx_halfvec_join #(.FRAC_BITS(32), .DEPTH(8), .SLACK(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .phi_valid(phi_valid), .cos_phi(cos_phi), .sin_phi(sin_phi),
      .th_valid(th_valid), .cos_theta(cos_theta), .sin_theta(sin_theta),
      .issue_ready(issue_ready), .out_valid(out_valid), .out_ready(out_ready),
      .hx(hx), .hy(hy), .hz(hz), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back({hx, hy, hz});
         cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pair(input logic [31:0] cp, sp, ct, st);
      cos_phi = cp; sin_phi = sp; cos_theta = ct; sin_theta = st;
   endtask

   task automatic pair_test(input string tag, input logic [31:0] cp, sp, ct, st,
                            input logic [95:0] exp);
      int n;
      phi_valid = 1'b1; th_valid = 1'b1;
      drive_pair(cp, sp, ct, st);
      tick();
      phi_valid = 1'b0; th_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 96'(n), 96'd2);
      chk(tag, {hx, hy, hz}, exp);
      tick();
      chk({tag, "_pulse"}, 96'(out_valid), 96'd0);
   endtask

   initial begin
      int   t0;
      logic stable;
      logic [95:0] snap;

      rst_n = 1'b0; out_ready = 1'b1; phi_valid = 1'b0; th_valid = 1'b0;
      drive_pair('0, '0, '0, '0);
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_out_valid", 96'(out_valid), 96'd0);
      chk("rst_h", {hx, hy, hz}, 96'd0);
      chk("rst_ovf", 96'(ovf_err), 96'd0);
      chk("rst_issue_ready", 96'(issue_ready), 96'd1);

      pair_test("t1", 32'h4000_0000, 32'h0000_0000, 32'h2D41_3CCD, 32'h2D41_3CCD,
                {32'h2D41_3CCD, 32'h0000_0000, 32'h2D41_3CCD});
      pair_test("t2", 32'hD2BE_C333, 32'hD2BE_C333, 32'h0000_0000, ONE,
                {32'hD2BE_C333, 32'hD2BE_C333, 32'h0000_0000});
      // 0.5 * +/-3 LSB = +/-1.5 LSB: rounds to +2 and -1
      pair_test("round", 32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_1234, 32'h2000_0000,
                {32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_1234});

      // Phi stream leads theta by 7 cycles
      got_q.delete(); cyc_q.delete(); t0 = 0;
      for (int i = 0; i < 12; i++) begin
         phi_valid = (i < 5);
         th_valid  = (i >= 7);
         if (i < 5) begin cos_phi = vcp[i]; sin_phi = vsp[i]; end
         if (i >= 7) begin cos_theta = vct[i-7]; sin_theta = ONE; end
         tick();
         if (i == 7) t0 = cyc;
      end
      phi_valid = 1'b0; th_valid = 1'b0;
      repeat (10) tick();
      chk("t3_count", 96'(got_q.size()), 96'd5);
      chk("t3_lat", 96'((cyc_q.size() > 0) ? cyc_q[0] - t0 : -1), 96'd2);
      for (int k = 0; k < 5; k++)
         chk($sformatf("t3_out%0d", k), (k < got_q.size()) ? got_q[k] : 'x, {vcp[k], vsp[k], vct[k]});

      // Downstream stall with four pairs queued
      got_q.delete();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         phi_valid = 1'b1; th_valid = 1'b1;
         drive_pair(vcp[k], vsp[k], vct[k], ONE);
         tick();
      end
      phi_valid = 1'b0; th_valid = 1'b0;
      repeat (3) tick();
      snap = {hx, hy, hz};
      stable = out_valid;
      repeat (10) begin
         tick();
         if (!out_valid || {hx, hy, hz} !== snap) stable = 1'b0;
      end
      chk("t4_hold", 96'(stable), 96'd1);
      chk("t4_head", snap, {vcp[0], vsp[0], vct[0]});
      chk("t4_none_while_stalled", 96'(got_q.size()), 96'd0);
      out_ready = 1'b1;
      repeat (8) tick();
      chk("t4_count", 96'(got_q.size()), 96'd4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t4_out%0d", k), (k < got_q.size()) ? got_q[k] : 'x, {vcp[k], vsp[k], vct[k]});

      // Phi-only fill: issue_ready is one cycle behind occupancy
      for (int k = 1; k <= 9; k++) begin
         phi_valid = 1'b1;
         cos_phi = 32'(k); sin_phi = 32'(k);
         tick();
         if (k == 5) chk("t5_ready_occ4", 96'(issue_ready), 96'd1);
         if (k == 6) chk("t5_ready_occ5", 96'(issue_ready), 96'd0);
         if (k == 8) chk("t5_no_ovf_at_full", 96'(ovf_err), 96'd0);
      end
      phi_valid = 1'b0;
      tick();
      chk("t5_ovf", 96'(ovf_err), 96'd1);
      repeat (3) tick();
      chk("t5_ovf_sticky", 96'(ovf_err), 96'd1);
      chk("t5_no_output", 96'(out_valid), 96'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_rst_ovf", 96'(ovf_err), 96'd0);
      chk("t5_rst_ready", 96'(issue_ready), 96'd1);

      // Reset with pairs in flight
      for (int k = 0; k < 3; k++) begin
         phi_valid = 1'b1; th_valid = 1'b1;
         drive_pair(vcp[k], vsp[k], vct[k], ONE);
         tick();
      end
      phi_valid = 1'b0; th_valid = 1'b0;
      chk("t6_inflight", 96'(out_valid), 96'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      got_q.delete();
      chk("t6_out_valid", 96'(out_valid), 96'd0);
      chk("t6_h", {hx, hy, hz}, 96'd0);
      chk("t6_ovf", 96'(ovf_err), 96'd0);
      chk("t6_ready", 96'(issue_ready), 96'd1);
      repeat (10) tick();
      chk("t6_no_stale", 96'(got_q.size()), 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
